// File: rtl/droplet_mux_ctrl.sv
// droplet_mux_ctrl: two-channel droplet MUX valve controller.
// Arbitrates between two mixer paths and sequences one transfer into the
// cell trap as IDLE -> SETTLE -> LOAD -> GAP.
// Optional feature: define DROPLET_MUX_CTRL_COUNT_EN to add the per-channel
// saturating completed-transfer counters cnt1/cnt2.
module droplet_mux_ctrl #(
   parameter int unsigned SETTLE_CYC = 4,
   parameter int unsigned DWELL_CYC  = 16,
   parameter int unsigned GAP_CYC    = 8,
   parameter int unsigned CW         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       trap_ready,
   input  logic       abort,
   output logic       cp1,
   output logic       cp2,
   output logic [1:0] gnt,
   output logic       busy,
   output logic       done
`ifdef DROPLET_MUX_CTRL_COUNT_EN
   ,
   output logic [7:0] cnt1,
   output logic [7:0] cnt2
`endif
);

   // Phase counter load values; a zero-length phase still lasts one cycle.
   localparam logic [CW-1:0] SettleLd = (SETTLE_CYC == 0) ? '0 : CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] DwellLd  = (DWELL_CYC == 0)  ? '0 : CW'(DWELL_CYC - 1);
   localparam logic [CW-1:0] GapLd    = (GAP_CYC == 0)    ? '0 : CW'(GAP_CYC - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StLoad,
      StGap
   } state_e;

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic          chan_q;  // channel of the transfer in flight (0 = path 1)
   logic          last_q;  // channel granted most recently
   logic          pick;
   logic          start;

   // Round-robin pick: a lone request wins outright, a tie goes to the
   // channel that was not served last.
   always_comb begin
      pick  = 1'b0;
      start = trap_ready && (req != 2'b00);
      if (req == 2'b11) begin
         pick = ~last_q;
      end else begin
         pick = req[1];
      end
   end

   // Transfer sequencer with registered valve, grant, busy and done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         chan_q  <= 1'b0;
         last_q  <= 1'b1;  // makes channel 0 the first tie winner
         cp1     <= 1'b0;
         cp2     <= 1'b0;
         gnt     <= 2'b00;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         gnt  <= 2'b00;
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StSettle;
                  cnt_q   <= SettleLd;
                  chan_q  <= pick;
                  last_q  <= pick;  // pointer moves at grant, so aborts advance it too
                  cp1     <= ~pick;
                  cp2     <= pick;
                  gnt     <= pick ? 2'b10 : 2'b01;
                  busy    <= 1'b1;
               end
            end
            StSettle: begin
               if (abort) begin
                  state_q <= StGap;
                  cnt_q   <= GapLd;
                  cp1     <= 1'b0;
                  cp2     <= 1'b0;
               end else if (cnt_q == '0) begin
                  state_q <= StLoad;
                  cnt_q   <= DwellLd;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StLoad: begin
               if (abort) begin
                  state_q <= StGap;
                  cnt_q   <= GapLd;
                  cp1     <= 1'b0;
                  cp2     <= 1'b0;
               end else if (cnt_q == '0) begin
                  state_q <= StGap;
                  cnt_q   <= GapLd;
                  cp1     <= 1'b0;
                  cp2     <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StGap: begin
               if (cnt_q == '0) begin
                  state_q <= StIdle;
                  busy    <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= '0;
               cp1     <= 1'b0;
               cp2     <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

`ifdef DROPLET_MUX_CTRL_COUNT_EN
   // Completed-transfer counters; chan_q still names the finished channel
   // while done is high in the first GAP cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt1 <= 8'd0;
         cnt2 <= 8'd0;
      end else if (done) begin
         if (!chan_q && (cnt1 != 8'hff)) begin
            cnt1 <= cnt1 + 8'd1;
         end
         if (chan_q && (cnt2 != 8'hff)) begin
            cnt2 <= cnt2 + 8'd1;
         end
      end
   end
`endif

endmodule
